// File: rtl/sram_req_rsp_adapter.sv
// Valid/ready front-end for a fixed-latency single-port SRAM. Reads are admitted
// only against a free response-FIFO credit, so read data is never dropped.
module sram_req_rsp_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned FifoDepth = 3,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntWidth = $clog2(FifoDepth + 1);
  localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [CntWidth-1:0] Depth   = CntWidth'(FifoDepth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(FifoDepth - 1);

  logic [CntWidth-1:0]  cnt, cnt_d;
  logic [CntWidth-1:0]  fcount, fcount_d;
  logic [Latency-1:0]   pend, pend_d;
  logic [PtrWidth-1:0]  wptr, rptr;
  logic [DataWidth-1:0] fifo_mem [FifoDepth];

  logic rd_accept, push, pop;

  // cnt covers both in-flight and buffered reads, so it is the admission credit.
  assign req_ready_o = !rst_i && (req_we_i || (cnt < Depth));
  assign sram_req_o  = req_valid_i && req_ready_o;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign rd_accept   = sram_req_o && !req_we_i;
  assign push        = pend[0];
  assign rsp_valid_o = (fcount != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? fifo_mem[rptr] : '0;

  if (Latency == 1) begin : g_pend_single
    assign pend_d = rd_accept;
  end else begin : g_pend_shift
    assign pend_d = {rd_accept, pend[Latency-1:1]};
  end

  always_comb begin
    cnt_d = cnt;
    if (rd_accept && !pop) begin
      cnt_d = cnt + CntWidth'(1);
    end else if (!rd_accept && pop) begin
      cnt_d = cnt - CntWidth'(1);
    end
  end

  always_comb begin
    fcount_d = fcount;
    if (push && !pop) begin
      fcount_d = fcount + CntWidth'(1);
    end else if (!push && pop) begin
      fcount_d = fcount - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      fcount <= '0;
      pend   <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      cnt    <= cnt_d;
      fcount <= fcount_d;
      pend   <= pend_d;
      if (push) begin
        wptr <= (wptr == LastPtr) ? '0 : wptr + PtrWidth'(1);
      end
      if (pop) begin
        rptr <= (rptr == LastPtr) ? '0 : rptr + PtrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wptr] <= sram_rdata_i;
    end
  end

`ifndef SYNTHESIS
  a_params: assert property (@(posedge clk_i) (Latency >= 1) && (FifoDepth >= 1))
    else $error("Latency and FifoDepth must both be >= 1");

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) push |-> (fcount < Depth))
    else $error("response FIFO push while full");

  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i && !req_ready_o) |=>
      (!req_valid_i || $stable({req_we_i, req_addr_i, req_wdata_i, req_be_i})))
    else $error("request fields changed while stalled");
`endif

endmodule

// File: doc/sram_req_rsp_adapter.md
Name: sram_req_rsp_adapter

Overview:
- Upstream front-end for a single-port `tc_sram` instance with fixed read latency.
- Converts a valid/ready request channel and a valid/ready response channel to the SRAM's req/we/addr/wdata/be interface.
- Read data returns after `Latency` cycles. It is captured in an in-order response FIFO, so the consumer can apply backpressure without losing data.
- Credit-based admission ensures no read is issued unless a FIFO slot is guaranteed.

Parameters:
- NumWords, 1024, words in the attached SRAM.
- DataWidth, 64, data width.
- ByteWidth, 8, bits per byte-enable lane.
- Latency, 1, SRAM read latency in cycles; must be >= 1.
- FifoDepth, 3, response FIFO entries; must be >= 1. Full throughput requires FifoDepth >= Latency+2.
- AddrWidth, derived: (NumWords>1) ? clog2(NumWords) : 1.
- BeWidth, derived: ceil(DataWidth/ByteWidth).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AddrWidth  word address.
- req_wdata_i  in  DataWidth  write data.
- req_be_i  in  BeWidth  byte enables (writes only).
- rsp_valid_o  out  1  read response valid.
- rsp_ready_i  in  1  read response ready.
- rsp_rdata_o  out  DataWidth  read data.
- sram_req_o  out  1  SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  SRAM address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  BeWidth  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid Latency cycles after a read request.

Behaviour:
- State:
  - credit counter cnt, width clog2(FifoDepth+1).
  - in-flight shift register pend[Latency-1:0].
  - FIFO storage with read/write pointers and count.
- Reset (rst_i high, asynchronous):
  - cnt = 0, pend = 0, FIFO empty.
  - rsp_valid_o = 0, rsp_rdata_o = 0.
  - req_ready_o forced 0 and sram_req_o forced 0 while rst_i is high.
- Admission:
  - req_ready_o = req_we_i | (cnt < FifoDepth).
  - Writes are always accepted.
  - req_ready_o has no combinational dependence on rsp_ready_i.
- Issue:
  - sram_req_o = req_valid_i & req_ready_o.
  - sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o are combinational pass-throughs of the request fields.
  - Zero added latency on the request path.
- Writes:
  - Complete silently; no response is produced.
  - Do not touch cnt or pend.
- Reads:
  - On a read accepted in cycle t: pend[Latency-1] <= 1 and cnt increments.
  - pend shifts toward index 0 each cycle.
  - When pend[0] = 1 in cycle t+Latency, sram_rdata_i is pushed into the FIFO at the end of that cycle.
- Response:
  - The FIFO is not fall-through.
  - rsp_valid_o = FIFO not empty; rsp_rdata_o = FIFO head.
  - Earliest rsp_valid_o is cycle t+Latency+1.
  - On rsp_valid_o & rsp_ready_i: pop the FIFO and decrement cnt.
- Counter rules:
  - Accept-read and pop in the same cycle: cnt unchanged.
  - cnt never exceeds FifoDepth.
  - FIFO push never occurs while full (guaranteed by credits). The simulation assertion fires if this is violated.
- Ordering:
  - Responses are strictly in request order.
  - Read-after-write to the same address in consecutive cycles returns the new data, per SRAM write-before-later-read ordering.
- Pointer wrap: FIFO pointers wrap modulo FifoDepth; FifoDepth need not be a power of two.
- Reset mid-operation: in-flight reads and buffered responses are discarded; no response appears after reset release.
- Simulation assertions (simulation only):
  - Latency >= 1 and FifoDepth >= 1.
  - No push when full.
  - req_* fields stable while req_valid_i & !req_ready_o.

Test Plan:
- Latency=1, FifoDepth=3, mem[5]=0xA5: read addr 5 accepted in cycle 0 -> sram_req_o=1 in cycle 0; rsp_valid_o=1 with rdata 0xA5 in cycle 2; cnt returns to 0 after handshake.
- Back-to-back reads of addr 0..7 with rsp_ready_i=1 -> req_ready_o stays 1 throughout; 8 responses in order on consecutive cycles 2..9.
- rsp_ready_i=0, issue 5 reads -> exactly 3 accepted, req_ready_o=0 from cycle 3. A write issued meanwhile is still accepted. After rsp_ready_i=1, 3 responses appear in order, then the remaining reads are admitted.
- Write addr 9 data 0x11223344_55667788 with be=0x0F over an initial value of 0 -> next-cycle read returns 0x00000000_55667788.
- Full FIFO (cnt=3) with rsp_ready_i=1 and a read valid in the same cycle -> read is not accepted that cycle (cnt=3 not < 3), pop occurs, and the read is accepted the next cycle; no FIFO overflow.
- Assert rst_i for 1 cycle with 2 reads in flight and 1 buffered -> rsp_valid_o=0 immediately; no responses after release; the next read behaves as in the first scenario.
